// File: rtl/tdoa_capture.sv
// -----------------------------------------------------------------------------
// tdoa_capture
//
// Captures the arrival delay of three hydrophone detections (det[3:1])
// relative to a reference detection (det[0]). Time is measured with an
// external shared cycle counter, which this block commands through
// counter_sel.
//
// Flow: IDLE --arm--> ARMED --det[0]--> RUN --all captured / timeout--> DONE
//       DONE --result_ack--> IDLE.   abort returns to IDLE from any state.
//
// Optional build macro:
//   TDOA_DEBOUNCE_EN  A channel qualifies only after two consecutive high
//                     cycles. Every channel, det[0] included, is delayed by
//                     the same cycle, so the reported delays are unchanged
//                     for clean pulses.
//
// Parameters:
//   WINDOW        capture window in clocks (legal range 2 .. 20'hFFFFE)
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   arm           single-cycle capture request (only honoured in IDLE)
//   abort         return to IDLE and clear results (highest priority)
//   det[3:0]      level detect flags; det[0] is the reference channel
//   counter_value current value of the shared cycle counter
//   counter_sel   counter command: 00 clear, 01 hold, 11 increment
//   tdoa1..3      delay of det[1..3] versus det[0] in clocks
//   missed[2:0]   bit i-1 set when channel i timed out
//   result_valid  results are stable (DONE)
//   result_ack    consumer has taken the results (only honoured in DONE)
//   busy          high in ARMED, RUN and DONE
// -----------------------------------------------------------------------------
module tdoa_capture #(
  parameter logic [19:0] WINDOW = 20'd200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        abort,
  input  logic [3:0]  det,
  input  logic [19:0] counter_value,
  output logic [1:0]  counter_sel,
  output logic [19:0] tdoa1,
  output logic [19:0] tdoa2,
  output logic [19:0] tdoa3,
  output logic [2:0]  missed,
  output logic        result_valid,
  input  logic        result_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_RUN   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] SEL_CLEAR = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b01;
  localparam logic [1:0] SEL_INC   = 2'b11;

  state_e state_q, state_d;

  logic [2:0][19:0] tdoa_q, tdoa_d;
  logic [2:0]       missed_q, missed_d;
  logic [2:0]       captured_q, captured_d;

  logic [3:0]  qual;
  logic [19:0] cycle_n;
  logic        start_run;
  logic        capture_en;
  logic [19:0] cap_time;
  logic [2:0]  cap_now;
  logic [2:0]  captured_all;
  logic        all_caught;
  logic        timeout;

  // ---------------------------------------------------------------------------
  // Detect qualification
  // ---------------------------------------------------------------------------
`ifdef TDOA_DEBOUNCE_EN
  logic [3:0] det_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) det_q <= '0;
    else       det_q <= det;
  end

  // Qualification lands on the second high cycle for every channel alike, so
  // the common one-cycle shift cancels out of the relative delays.
  assign qual = det & det_q;
`else
  assign qual = det;
`endif

  // ---------------------------------------------------------------------------
  // Capture datapath
  // ---------------------------------------------------------------------------
  // The counter is cleared while ARMED and reads 0 in the first RUN cycle,
  // which is cycle 1 relative to the reference detection.
  assign cycle_n      = counter_value + 20'd1;
  assign start_run    = (state_q == S_ARMED) && qual[0];
  assign capture_en   = start_run || (state_q == S_RUN);
  assign cap_time     = (state_q == S_RUN) ? cycle_n : 20'd0;
  assign cap_now      = qual[3:1] & ~captured_q & {3{capture_en}};
  assign captured_all = captured_q | cap_now;
  assign all_caught   = &captured_all;
  // A capture in the last window cycle is folded into captured_all first,
  // so a simultaneous last capture suppresses the timeout.
  assign timeout      = (state_q == S_RUN) && (cycle_n == WINDOW - 20'd1) && !all_caught;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    tdoa_d     = tdoa_q;
    missed_d   = missed_q;
    captured_d = captured_q;

    if (abort || ((state_q == S_IDLE) && arm)) begin
      // Abort discards results; a new arm starts from a clean slate.
      tdoa_d     = '0;
      missed_d   = '0;
      captured_d = '0;
    end else begin
      captured_d = captured_all;
      for (int i = 0; i < 3; i++) begin
        if (cap_now[i]) tdoa_d[i] = cap_time;
      end
      if (timeout) begin
        for (int i = 0; i < 3; i++) begin
          if (!captured_all[i]) tdoa_d[i] = 20'hFFFFF;
        end
        missed_d = ~captured_all;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; reset is asynchronous so the
  // outputs clear without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdoa_q     <= '0;
      missed_q   <= '0;
      captured_q <= '0;
    end else begin
      tdoa_q     <= tdoa_d;
      missed_q   <= missed_d;
      captured_q <= captured_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (arm)                    state_d = S_ARMED;
        // All three channels may coincide with the reference.
        S_ARMED: if (start_run)              state_d = all_caught ? S_DONE : S_RUN;
        S_RUN:   if (all_caught || timeout)  state_d = S_DONE;
        S_DONE:  if (result_ack)             state_d = S_IDLE;
        default:                             state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    counter_sel  = SEL_CLEAR;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_ARMED: counter_sel = SEL_CLEAR;
      S_RUN:   counter_sel = SEL_INC;
      S_DONE: begin
        counter_sel  = SEL_HOLD;
        result_valid = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign tdoa1  = tdoa_q[0];
  assign tdoa2  = tdoa_q[1];
  assign tdoa3  = tdoa_q[2];
  assign missed = missed_q;

endmodule

// File: tb/tb_tdoa_capture.sv
// -----------------------------------------------------------------------------
// tb_tdoa_capture
//
// Directed testbench for tdoa_capture with WINDOW=100. The shared cycle
// counter is modelled here and driven by the DUT's counter_sel. Stimulus is
// described per run as a start cycle and width for each det channel, counted
// from the first high cycle of det[0]. When TDOA_DEBOUNCE_EN is defined the
// pulses are two cycles wide and DONE arrives one cycle later.
// -----------------------------------------------------------------------------
module tb_tdoa_capture;

  localparam logic [19:0] WIN = 20'd100;
`ifdef TDOA_DEBOUNCE_EN
  localparam int PW  = 2;
  localparam int LAT = 1;
`else
  localparam int PW  = 1;
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [3:0]  det;
  logic [19:0] counter_value;
  logic [1:0]  counter_sel;
  logic [19:0] tdoa1, tdoa2, tdoa3;
  logic [2:0]  missed;
  logic        result_valid;
  logic        result_ack;
  logic        busy;

  tdoa_capture #(.WINDOW(WIN)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .det          (det),
    .counter_value(counter_value),
    .counter_sel  (counter_sel),
    .tdoa1        (tdoa1),
    .tdoa2        (tdoa2),
    .tdoa3        (tdoa3),
    .missed       (missed),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Shared cycle counter model
  logic [19:0] cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else begin
      case (counter_sel)
        2'b00:   cnt <= '0;
        2'b11:   cnt <= cnt + 20'd1;
        default: cnt <= cnt;
      endcase
    end
  end
  assign counter_value = cnt;

  int errors = 0;
  int checks = 0;
  int cyc;
  int done_cyc;
  int st [4];
  int ln [4];
  int glitch;
  int abort_at;
  int poke_at;
  logic [1:0] sel_mid;
  logic       busy_mid;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_arm;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task do_ack;
    result_ack = 1'b1;
    tick;
    result_ack = 1'b0;
  endtask

  // Start cycle per channel (-1 = never), common pulse width.
  task set_sched(input int s0, input int s1, input int s2, input int s3, input int w);
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
    for (int i = 0; i < 4; i++) ln[i] = (st[i] < 0) ? 0 : w;
    glitch   = -1;
    abort_at = -1;
    poke_at  = -1;
  endtask

  // Drive the schedule from ARMED until DONE, abort, or the cycle budget.
  task run_capture;
    cyc      = 0;
    done_cyc = -1;
    while (cyc < 300) begin
      for (int i = 0; i < 4; i++)
        det[i] = ((cyc >= st[i]) && (cyc < st[i] + ln[i])) || ((i == 1) && (cyc == glitch));
      abort      = (cyc == abort_at);
      arm        = (cyc == poke_at);
      result_ack = (cyc == poke_at);
      tick;
      cyc++;
      abort      = 1'b0;
      arm        = 1'b0;
      result_ack = 1'b0;
      if (cyc == 10) begin
        sel_mid  = counter_sel;
        busy_mid = busy;
      end
      if ((abort_at >= 0) && (cyc == abort_at + 1)) break;
      if (result_valid) begin
        done_cyc = cyc;
        break;
      end
    end
    det = '0;
  endtask

  task test_reset;
    reset = 1'b1; arm = 1'b0; abort = 1'b0; det = '0; result_ack = 1'b0;
    #3;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", result_valid); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end checks++;
    if (counter_sel !== 2'b00) begin errors++; $display("FAIL rst_sel: got %b expected 00", counter_sel); end checks++;
    if ({tdoa1, tdoa2, tdoa3} !== 60'd0) begin errors++; $display("FAIL rst_tdoa: got %h %h %h expected 0 0 0", tdoa1, tdoa2, tdoa3); end checks++;
    if (missed !== 3'b000) begin errors++; $display("FAIL rst_missed: got %b expected 000", missed); end checks++;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task test_basic;
    do_arm;
    if (busy !== 1'b1) begin errors++; $display("FAIL armed_busy: got %b expected 1", busy); end checks++;
    if (counter_sel !== 2'b00) begin errors++; $display("FAIL armed_sel: got %b expected 00", counter_sel); end checks++;
    set_sched(0, 5, 12, 40, PW);
    poke_at = 3;  // arm and result_ack during RUN must be ignored
    run_capture;
    if (done_cyc !== 41 + LAT) begin errors++; $display("FAIL s1_done_cycle: got %0d expected %0d", done_cyc, 41 + LAT); end checks++;
    if (sel_mid !== 2'b11) begin errors++; $display("FAIL s1_run_sel: got %b expected 11", sel_mid); end checks++;
    if (busy_mid !== 1'b1) begin errors++; $display("FAIL s1_run_busy: got %b expected 1", busy_mid); end checks++;
    if (tdoa1 !== 20'd5) begin errors++; $display("FAIL s1_tdoa1: got %0d expected 5", tdoa1); end checks++;
    if (tdoa2 !== 20'd12) begin errors++; $display("FAIL s1_tdoa2: got %0d expected 12", tdoa2); end checks++;
    if (tdoa3 !== 20'd40) begin errors++; $display("FAIL s1_tdoa3: got %0d expected 40", tdoa3); end checks++;
    if (missed !== 3'b000) begin errors++; $display("FAIL s1_missed: got %b expected 000", missed); end checks++;
    if (counter_sel !== 2'b01) begin errors++; $display("FAIL s1_done_sel: got %b expected 01", counter_sel); end checks++;
    repeat (3) tick;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL s1_hold_valid: got %b expected 1", result_valid); end checks++;
    if (tdoa3 !== 20'd40) begin errors++; $display("FAIL s1_hold_tdoa3: got %0d expected 40", tdoa3); end checks++;
    do_ack;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL s1_ack_valid: got %b expected 0", result_valid); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL s1_ack_busy: got %b expected 0", busy); end checks++;
    if (counter_sel !== 2'b00) begin errors++; $display("FAIL s1_ack_sel: got %b expected 00", counter_sel); end checks++;
  endtask

  task test_coincident;
    do_arm;
    set_sched(0, 3, 0, 7, PW);
    run_capture;
    if (tdoa2 !== 20'd0) begin errors++; $display("FAIL s2_tdoa2: got %0d expected 0", tdoa2); end checks++;
    if (tdoa1 !== 20'd3) begin errors++; $display("FAIL s2_tdoa1: got %0d expected 3", tdoa1); end checks++;
    if (tdoa3 !== 20'd7) begin errors++; $display("FAIL s2_tdoa3: got %0d expected 7", tdoa3); end checks++;
    do_ack;
  endtask

  task test_timeout;
    do_arm;
    set_sched(0, 10, 20, -1, PW);
    run_capture;
    if (done_cyc !== 100 + LAT) begin errors++; $display("FAIL s3_done_cycle: got %0d expected %0d", done_cyc, 100 + LAT); end checks++;
    if (tdoa3 !== 20'hFFFFF) begin errors++; $display("FAIL s3_tdoa3: got %h expected fffff", tdoa3); end checks++;
    if (missed !== 3'b100) begin errors++; $display("FAIL s3_missed: got %b expected 100", missed); end checks++;
    if (tdoa1 !== 20'd10) begin errors++; $display("FAIL s3_tdoa1: got %0d expected 10", tdoa1); end checks++;
    if (tdoa2 !== 20'd20) begin errors++; $display("FAIL s3_tdoa2: got %0d expected 20", tdoa2); end checks++;
    do_ack;
  endtask

  task test_capture_wins;
    do_arm;
    set_sched(0, 1, 2, 99, PW);
    run_capture;
    if (done_cyc !== 100 + LAT) begin errors++; $display("FAIL edge_done_cycle: got %0d expected %0d", done_cyc, 100 + LAT); end checks++;
    if (missed !== 3'b000) begin errors++; $display("FAIL edge_missed: got %b expected 000", missed); end checks++;
    if (tdoa3 !== 20'd99) begin errors++; $display("FAIL edge_tdoa3: got %0d expected 99", tdoa3); end checks++;
    do_ack;
  endtask

  task test_abort;
    do_arm;
    set_sched(0, 5, -1, -1, PW);
    abort_at = 20;
    run_capture;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL s4_valid: got %b expected 0", result_valid); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL s4_busy: got %b expected 0", busy); end checks++;
    if (counter_sel !== 2'b00) begin errors++; $display("FAIL s4_sel: got %b expected 00", counter_sel); end checks++;
    if (tdoa1 !== 20'd0) begin errors++; $display("FAIL s4_tdoa1_cleared: got %0d expected 0", tdoa1); end checks++;
    // Clean restart
    do_arm;
    set_sched(0, 7, 8, 9, PW);
    run_capture;
    if (done_cyc !== 10 + LAT) begin errors++; $display("FAIL s4_restart_done: got %0d expected %0d", done_cyc, 10 + LAT); end checks++;
    if ({tdoa1, tdoa2, tdoa3} !== {20'd7, 20'd8, 20'd9}) begin errors++; $display("FAIL s4_restart_tdoa: got %0d %0d %0d expected 7 8 9", tdoa1, tdoa2, tdoa3); end checks++;
    // Abort beats result_ack in DONE: results are cleared, not merely released
    abort = 1'b1; result_ack = 1'b1;
    tick;
    abort = 1'b0; result_ack = 1'b0;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_ack_busy: got %b expected 0", busy); end checks++;
    if (tdoa1 !== 20'd0) begin errors++; $display("FAIL abort_ack_tdoa1: got %0d expected 0", tdoa1); end checks++;
    // Abort beats arm in IDLE
    abort = 1'b1; arm = 1'b1;
    tick;
    abort = 1'b0; arm = 1'b0;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_arm_busy: got %b expected 0", busy); end checks++;
  endtask

  task test_glitch;
    do_arm;
    set_sched(0, 9, 11, 12, PW);
    ln[1]  = 6;
    glitch = 3;
    run_capture;
`ifdef TDOA_DEBOUNCE_EN
    if (tdoa1 !== 20'd9) begin errors++; $display("FAIL s6_tdoa1: got %0d expected 9", tdoa1); end checks++;
`else
    if (tdoa1 !== 20'd3) begin errors++; $display("FAIL s6_tdoa1: got %0d expected 3", tdoa1); end checks++;
`endif
    if ({tdoa2, tdoa3} !== {20'd11, 20'd12}) begin errors++; $display("FAIL s6_tdoa23: got %0d %0d expected 11 12", tdoa2, tdoa3); end checks++;
    do_ack;
  endtask

  task test_reset_in_done;
    do_arm;
    set_sched(0, 2, 4, 6, PW);
    run_capture;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL s5_pre_valid: got %b expected 1", result_valid); end checks++;
    #2;
    reset = 1'b1;
    #1;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL s5_valid: got %b expected 0", result_valid); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL s5_busy: got %b expected 0", busy); end checks++;
    if (counter_sel !== 2'b00) begin errors++; $display("FAIL s5_sel: got %b expected 00", counter_sel); end checks++;
    if ({tdoa1, tdoa2, tdoa3} !== 60'd0) begin errors++; $display("FAIL s5_tdoa: got %0d %0d %0d expected 0 0 0", tdoa1, tdoa2, tdoa3); end checks++;
    if (missed !== 3'b000) begin errors++; $display("FAIL s5_missed: got %b expected 000", missed); end checks++;
    tick;
    reset = 1'b0;
    tick;
    // Detections without a fresh arm start nothing
    det = 4'b1111;
    tick;
    tick;
    det = '0;
    if (busy !== 1'b0) begin errors++; $display("FAIL s5_no_arm_busy: got %b expected 0", busy); end checks++;
    if (tdoa1 !== 20'd0) begin errors++; $display("FAIL s5_no_arm_tdoa1: got %0d expected 0", tdoa1); end checks++;
    do_arm;
    set_sched(0, 1, 2, 3, PW);
    run_capture;
    if ({tdoa1, tdoa2, tdoa3} !== {20'd1, 20'd2, 20'd3}) begin errors++; $display("FAIL s5_rearm_tdoa: got %0d %0d %0d expected 1 2 3", tdoa1, tdoa2, tdoa3); end checks++;
    do_ack;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_coincident;
    test_timeout;
    test_capture_wins;
    test_abort;
    test_glitch;
    test_reset_in_done;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
